// File: rtl/sdram_axi_arb.sv
// sdram_axi_arb: N-port command arbiter in front of a single SDRAM core.
// Forwards one upstream command per cycle on a zero-cycle path, locks onto
// a port for the remaining beats of a burst, and keeps a FIFO of port IDs
// so that core acks can be routed back to the port that issued the command.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | arbitrate among all requesting ports (fixed or round robin)
// ST_LOCKED | burst in progress, only lock_port is forwarded

module sdram_axi_arb #(
    parameter int DW       = 32,
    parameter int NPORTS   = 2,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NPORTS*DW/8-1:0] in_wr_i,
    input  logic [NPORTS-1:0]      in_rd_i,
    input  logic [NPORTS*8-1:0]    in_len_i,
    input  logic [NPORTS*32-1:0]   in_addr_i,
    input  logic [NPORTS*DW-1:0]   in_wdata_i,
    output logic [NPORTS-1:0]      in_accept_o,
    output logic [NPORTS-1:0]      in_ack_o,
    output logic [NPORTS*DW-1:0]   in_rdata_o,
    output logic [DW/8-1:0]        out_wr_o,
    output logic                   out_rd_o,
    output logic [7:0]             out_len_o,
    output logic [31:0]            out_addr_o,
    output logic [DW-1:0]          out_wdata_o,
    input  logic                   out_accept_i,
    input  logic                   out_ack_i,
    input  logic [DW-1:0]          out_rdata_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(NPORTS);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state;
    logic [PW-1:0]     lock_port;
    logic [PW-1:0]     rr_ptr;
    logic [7:0]        beat_cnt;

    logic [NPORTS-1:0] req;
    logic [PW-1:0]     grant;
    logic [PW-1:0]     cand;
    logic              grant_vld;
    logic              fire_ok;
    logic              accept;

    logic [PW-1:0]     fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [PW-1:0]     head;

    // A port requests when any write strobe or its read line is set
    always_comb begin
        req = '0;
        for (int p = 0; p < NPORTS; p++) begin
            req[p] = (|in_wr_i[p*BW +: BW]) | in_rd_i[p];
        end
    end

    // Grant selection: lock port while bursting, else search from the pointer
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        if (state == ST_LOCKED) begin
            grant     = lock_port;
            grant_vld = req[lock_port];
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (ARB_MODE == 1) begin
                    cand = PW'((int'(rr_ptr) + i) % NPORTS);
                end else begin
                    cand = PW'(i);
                end
                if (!grant_vld && req[cand]) begin
                    grant_vld = 1'b1;
                    grant     = cand;
                end
            end
        end
        // Nothing may be forwarded or accepted while reset is asserted
        if (!rst_ni) begin
            grant_vld = 1'b0;
        end
    end

    assign fire_ok = grant_vld && !full;
    assign accept  = fire_ok && out_accept_i;
    assign push    = accept;
    assign empty   = (count == '0);
    assign pop     = out_ack_i && !empty;
    assign head    = fifo_mem[rd_ptr];

    // Zero-cycle forwarding of the granted port's command to the core
    always_comb begin
        out_len_o   = in_len_i[int'(grant)*8 +: 8];
        out_addr_o  = in_addr_i[int'(grant)*32 +: 32];
        out_wdata_o = in_wdata_i[int'(grant)*DW +: DW];
        out_wr_o    = fire_ok ? in_wr_i[int'(grant)*BW +: BW] : '0;
        out_rd_o    = fire_ok ? in_rd_i[grant] : 1'b0;
    end

    // Per-port accept and ack strobes
    always_comb begin
        in_accept_o = '0;
        in_ack_o    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            in_accept_o[p] = accept && (grant == PW'(p));
            in_ack_o[p]    = pop && (head == PW'(p));
        end
    end

    assign in_rdata_o = {NPORTS{out_rdata_i}};
    assign busy_o     = (state == ST_LOCKED) || !empty;
    assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);

    // Arbitration state: burst lock, beat counter and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            lock_port <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                rr_ptr <= (grant == PW'(NPORTS - 1)) ? '0 : grant + 1'b1;
                if (out_len_o != 8'd0) begin
                    state     <= ST_LOCKED;
                    lock_port <= grant;
                    beat_cnt  <= out_len_o;
                end
            end else begin
                beat_cnt <= beat_cnt - 8'd1;
                if (beat_cnt == 8'd1) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    // ID FIFO pointers and occupancy; full is registered so a pop never frees a slot in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
        end
    end

    // ID FIFO storage, contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

    // Sticky error on an ack with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (out_ack_i && empty) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: doc/sdram_axi_arb.md
SDRAM_AXI_ARB -- requirements
Module: sdram_axi_arb

Interface
REQ-001 SHALL have parameter DW, default 32: data width; DW/8 byte strobes.
REQ-002 SHALL have parameter NPORTS, default 2: number of upstream RAM ports, legal range 2..8.
REQ-003 SHALL have parameter DEPTH, default 4: maximum outstanding accepted commands; power of 2, range 2..16.
REQ-004 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (port 0 highest); 1 = round robin.
REQ-005 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_wr_i, input, NPORTS*DW/8: per-port write byte strobes; any bit set means a write request.
REQ-008 SHALL have port in_rd_i, input, NPORTS: per-port read request.
REQ-009 SHALL have port in_len_i, input, NPORTS*8: per-port burst length minus one.
REQ-010 SHALL have port in_addr_i, input, NPORTS*32: per-port byte address.
REQ-011 SHALL have port in_wdata_i, input, NPORTS*DW: per-port write data.
REQ-012 SHALL have port in_accept_o, output, NPORTS: per-port command accepted this cycle.
REQ-013 SHALL have port in_ack_o, output, NPORTS: per-port response strobe.
REQ-014 SHALL have port in_rdata_o, output, NPORTS*DW: per-port read data.
REQ-015 SHALL have outputs out_wr_o (DW/8), out_rd_o (1), out_len_o (8), out_addr_o (32), out_wdata_o (DW): the command forwarded to the SDRAM core.
REQ-016 SHALL have inputs out_accept_i (1), out_ack_i (1), out_rdata_i (DW): the core's accept, ack and read data.
REQ-017 SHALL have outputs busy_o (1): burst locked or commands outstanding; err_o (1): sticky protocol error.

Function
REQ-018 Port p SHALL be requesting when any in_wr_i bit of port p is set or in_rd_i[p] is set.
REQ-019 SHALL implement a two-state FSM, IDLE and LOCKED, with a lock port register and an 8-bit beat counter.
REQ-020 In IDLE, the grant SHALL go combinationally to the winner among requesting ports; in ARB_MODE 1 the search starts at the round-robin pointer and wraps from NPORTS-1 to 0.
REQ-021 In LOCKED, only the lock port SHALL be forwarded; other ports are ignored.
REQ-022 The granted port's wr, rd, len, addr and wdata SHALL drive out_* in the same cycle (zero-cycle path); with no grant or with the FIFO full, out_wr_o and out_rd_o SHALL be 0.
REQ-023 in_accept_o[p] SHALL equal out_accept_i AND grant==p AND FIFO not full; at most one bit is set per cycle.
REQ-024 On an accept in IDLE with len>0: go to LOCKED, lock port = winner, counter = len.
REQ-025 On an accept in IDLE with len==0: stay in IDLE.
REQ-026 On any IDLE accept, the round-robin pointer SHALL become (winner+1) mod NPORTS.
REQ-027 On each accept in LOCKED, the counter SHALL decrement; an accept with counter==1 SHALL return the FSM to IDLE.
REQ-028 The ID FIFO (DEPTH entries of port index) SHALL push the granted port on every accepted command.
REQ-029 "Full" SHALL be registered: a push is blocked while full, even if a pop occurs in the same cycle.
REQ-030 On out_ack_i with the FIFO non-empty: pop the head, assert in_ack_o[head] combinationally in the same cycle, and drive out_rdata_i to every in_rdata_o lane.
REQ-031 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-032 out_ack_i with the FIFO empty SHALL assert no in_ack_o and SHALL set err_o; err_o stays set until reset.
REQ-033 busy_o SHALL equal (state==LOCKED) OR (FIFO not empty).
REQ-034 A requesting port that is not granted SHALL see in_accept_o=0 and SHALL hold its request; the block needs no request/accept ordering beyond this.

Reset
REQ-035 While rst_ni=0, the following SHALL hold: state IDLE, counter 0, round-robin pointer 0, FIFO empty, err_o 0, busy_o 0, in_accept_o 0, in_ack_o 0, out_wr_o 0, out_rd_o 0.
REQ-036 Reset mid-burst or with commands outstanding SHALL discard the lock and all FIFO entries; stray acks after reset SHALL set err_o per REQ-032.

Verification
REQ-037 Round robin, NPORTS=2, both ports issuing single reads (len 0), out_accept_i=1 -> grants alternate 0,1,0,1; ack order matches accept order.
REQ-038 Burst lock: port 1 writes len=3 while port 0 requests reads -> exactly four consecutive accepts to port 1, then port 0 is granted; FSM returns to IDLE on the fourth accept.
REQ-039 FIFO full, DEPTH=4, no acks -> four accepts, then out_rd_o=0 and in_accept_o=0; one ack -> in_ack_o to the oldest port, and the next command is accepted one cycle later.
REQ-040 Fixed priority, ARB_MODE 0, ports 0 and 2 requesting continuously -> port 2 is never granted while port 0 requests.
REQ-041 Stray ack with the FIFO empty -> err_o=1 and all in_ack_o=0; err_o clears only on rst_ni=0.
REQ-042 rst_ni pulled low mid-burst, counter=2 -> all outputs at reset values immediately; after release, the next request starts a fresh IDLE arbitration from pointer 0.
